// File: rtl/mdu.sv
// Multiply/divide unit with HI/LO registers: multi-cycle mult/div with fixed
// latency, plus direct HI/LO moves and a combinational read port.
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  MDUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] Out
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state, state_n;
    logic [31:0] cnt, cnt_n;
    logic [31:0] a_q, a_n, b_q, b_n;
    logic [3:0]  op_q, op_n;
    logic [31:0] hi_n, lo_n;

    logic        is_md;
    logic [63:0] prod_s, prod_u;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;

    assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    assign prod_u = {32'd0, a_q} * {32'd0, b_q};

    // Divide on magnitudes so the 0x80000000 / -1 case wraps cleanly instead of overflowing
    assign a_neg  = (op_q == OP_DIV) && a_q[31];
    assign b_neg  = (op_q == OP_DIV) && b_q[31];
    assign a_mag  = a_neg ? (~a_q + 32'd1) : a_q;
    assign b_mag  = b_neg ? (~b_q + 32'd1) : b_q;
    assign b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
    assign q_mag  = a_mag / b_safe;
    assign r_mag  = a_mag % b_safe;
    assign quot   = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    assign rem    = a_neg ? (~r_mag + 32'd1) : r_mag;

    assign is_md = (MDUOp >= OP_MULT) && (MDUOp <= OP_DIVU);
    assign Busy  = (state == BUSY);
    assign Start = is_md && (state == IDLE);
    assign Out   = (MDUOp == OP_MFHI) ? HI : (MDUOp == OP_MFLO) ? LO : 32'd0;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        a_n     = a_q;
        b_n     = b_q;
        op_n    = op_q;
        hi_n    = HI;
        lo_n    = LO;
        case (state)
            IDLE: begin
                if (is_md) begin
                    a_n     = A;
                    b_n     = B;
                    op_n    = MDUOp;
                    cnt_n   = (MDUOp == OP_MULT || MDUOp == OP_MULTU) ?
                              32'(MULT_CYCLES) : 32'(DIV_CYCLES);
                    state_n = BUSY;
                end else if (MDUOp == OP_MTHI) begin
                    hi_n = A;
                end else if (MDUOp == OP_MTLO) begin
                    lo_n = A;
                end
            end
            BUSY: begin
                cnt_n = cnt - 32'd1;
                if (cnt == 32'd1) begin
                    state_n = IDLE;
                    case (op_q)
                        OP_MULT:  {hi_n, lo_n} = prod_s;
                        OP_MULTU: {hi_n, lo_n} = prod_u;
                        OP_DIV, OP_DIVU: begin
                            if (b_q != 32'd0) begin
                                lo_n = quot;
                                hi_n = rem;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            HI    <= '0;
            LO    <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            a_q   <= a_n;
            b_q   <= b_n;
            op_q  <= op_n;
            HI    <= hi_n;
            LO    <= lo_n;
        end
    end

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: latency, arithmetic results, moves, ignored ops and reset.
module tb_mdu;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  MDUOp;
    logic [31:0] A, B;
    logic        Start, Busy;
    logic [31:0] HI, LO, Out;

    int errors = 0;
    int checks = 0;

    mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .MDUOp(MDUOp), .A(A), .B(B),
        .Start(Start), .Busy(Busy), .HI(HI), .LO(LO), .Out(Out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a mult/div, then count the cycles Busy stays high (bounded)
    task automatic run_op(input string tag, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b, input int exp_cycles);
        int n;
        MDUOp = op; A = a; B = b;
        #1;
        check({tag, "_start"}, {31'd0, Start}, 32'd1);
        tick();
        MDUOp = 4'd0;
        n = 0;
        while (Busy && n < 100) begin
            n++;
            tick();
        end
        check({tag, "_busylen"}, n, exp_cycles);
    endtask

    initial begin
        int n;
        reset = 1'b0; MDUOp = 4'd0; A = '0; B = '0;
        tick(); tick();
        check("rst_busy", {31'd0, Busy}, 32'd0);
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);
        check("rst_start", {31'd0, Start}, 32'd0);
        reset = 1'b1;
        tick();

        run_op("mult", 4'd1, 32'hFFFFFFFF, 32'd2, 5);
        check("mult_hi", HI, 32'hFFFFFFFF);
        check("mult_lo", LO, 32'hFFFFFFFE);

        run_op("multu", 4'd2, 32'hFFFFFFFF, 32'd2, 5);
        check("multu_hi", HI, 32'h00000001);
        check("multu_lo", LO, 32'hFFFFFFFE);

        run_op("div", 4'd3, 32'hFFFFFFF9, 32'd2, 10);
        check("div_lo", LO, 32'hFFFFFFFD);
        check("div_hi", HI, 32'hFFFFFFFF);

        run_op("divu", 4'd4, 32'd7, 32'd2, 10);
        check("divu_lo", LO, 32'd3);
        check("divu_hi", HI, 32'd1);

        run_op("divovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, 10);
        check("divovf_lo", LO, 32'h80000000);
        check("divovf_hi", HI, 32'd0);

        MDUOp = 4'd7; A = 32'hAAAA0000; tick();
        check("mthi_hi", HI, 32'hAAAA0000);
        MDUOp = 4'd8; A = 32'h5555FFFF; tick();
        check("mtlo_lo", LO, 32'h5555FFFF);
        check("mtlo_hi_kept", HI, 32'hAAAA0000);
        run_op("div0", 4'd3, 32'd5, 32'd0, 10);
        check("div0_hi", HI, 32'hAAAA0000);
        check("div0_lo", LO, 32'h5555FFFF);

        MDUOp = 4'd7; A = 32'h12345678; tick();
        MDUOp = 4'd5; #1;
        check("mfhi_out", Out, 32'h12345678);
        MDUOp = 4'd6; #1;
        check("mflo_out", Out, 32'h5555FFFF);
        MDUOp = 4'd9; #1;
        check("op9_out", Out, 32'd0);
        check("op9_start", {31'd0, Start}, 32'd0);

        // mult -3*5, with mtlo, multu and mfhi presented while busy
        MDUOp = 4'd1; A = 32'hFFFFFFFD; B = 32'd5; tick();
        MDUOp = 4'd8; A = 32'hDEADBEEF; B = 32'd0; #1;
        check("busy_mtlo_start", {31'd0, Start}, 32'd0);
        tick();
        MDUOp = 4'd2; A = 32'd7; B = 32'd7; #1;
        check("busy_multu_start", {31'd0, Start}, 32'd0);
        tick();
        MDUOp = 4'd5; #1;
        check("busy_mfhi_stale", Out, 32'h12345678);
        MDUOp = 4'd0;
        n = 0;
        while (Busy && n < 100) begin n++; tick(); end
        check("busyops_busylen", n, 3);
        check("busyops_hi", HI, 32'hFFFFFFFF);
        check("busyops_lo", LO, 32'hFFFFFFF1);
        tick();
        check("busyops_no_restart", {31'd0, Busy}, 32'd0);

        // Reset in the 4th busy cycle of div 100/7
        MDUOp = 4'd3; A = 32'd100; B = 32'd7; tick();
        MDUOp = 4'd0;
        tick(); tick(); tick();
        check("rstmid_busy_before", {31'd0, Busy}, 32'd1);
        reset = 1'b0; tick();
        check("rstmid_busy", {31'd0, Busy}, 32'd0);
        check("rstmid_hi", HI, 32'd0);
        check("rstmid_lo", LO, 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        check("rstmid_late_hi", HI, 32'd0);
        check("rstmid_late_lo", LO, 32'd0);

        // Reset wins over mthi at the same edge
        MDUOp = 4'd7; A = 32'hCAFEF00D; reset = 1'b0; tick();
        check("rst_over_mthi", HI, 32'd0);
        reset = 1'b1; MDUOp = 4'd0; tick();

        run_op("b2b_divu", 4'd4, 32'd9, 32'd2, 10);
        check("b2b_divu_hi", HI, 32'd1);
        check("b2b_divu_lo", LO, 32'd4);
        run_op("b2b_mult", 4'd1, 32'd3, 32'd4, 5);
        check("b2b_mult_hi", HI, 32'd0);
        check("b2b_mult_lo", LO, 32'd12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
